// File: rtl/csr_pkg.sv
// Shared definitions for the RSA control/status register file:
// register byte offsets, AXI response codes and status bit positions.
package csr_pkg;

    // Register byte offsets. STATUS shares offset 0 with COMMAND (read side).
    localparam int unsigned COMMAND = 0;
    localparam int unsigned RXADDR  = 4;
    localparam int unsigned TXADDR  = 8;
    localparam int unsigned T       = 12;
    localparam int unsigned T_LEN   = 16;
    localparam int unsigned LOADING = 20;
    localparam int unsigned STATUS  = 0;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Bit positions inside the core status word.
    localparam int unsigned DONE_BIT      = 0;
    localparam int unsigned LOAD_DONE_BIT = 9;

    // Register index used by the decoder; SEL_NONE marks an unmapped address.
    typedef enum logic [2:0] {
        SEL_COMMAND = 3'd0,
        SEL_RXADDR  = 3'd1,
        SEL_TXADDR  = 3'd2,
        SEL_T       = 3'd3,
        SEL_T_LEN   = 3'd4,
        SEL_LOADING = 3'd5,
        SEL_NONE    = 3'd7
    } reg_sel_e;

    // Convenience accessors for software-visible status flags.
    function automatic logic rsa_done(input logic [31:0] st);
        return st[DONE_BIT];
    endfunction

    function automatic logic load_done(input logic [31:0] st);
        return st[LOAD_DONE_BIT];
    endfunction

endpackage

// File: rtl/axil_ready_pulse.sv
// One-shot AXI-Lite ready generator with a hold flag. Ready is a registered
// single-cycle pulse, so a valid held for an extra cycle is never accepted
// twice; hold stays set from the handshake until the consumer clears it.
module axil_ready_pulse (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic block,
    input  logic clear,
    output logic ready,
    output logic hold
);

    // Pulse ready once per transfer and remember that a beat was taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready <= 1'b0;
            hold  <= 1'b0;
        end else begin
            ready <= valid && !ready && !hold && !block;
            if (clear) begin
                hold <= 1'b0;
            end else if (valid && ready) begin
                hold <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/axil_csr_responder.sv
// AXI4-Lite responder for the RSA core's register file. Six word registers
// are exposed as static outputs; COMMAND and LOADING writes also produce a
// one-cycle strobe. Reads of offset 0 return the live core status word.
module axil_csr_responder
    import csr_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   s_axi_csrs_awaddr,
    input  logic                s_axi_csrs_awvalid,
    output logic                s_axi_csrs_awready,
    input  logic [DATA_W-1:0]   s_axi_csrs_wdata,
    input  logic [DATA_W/8-1:0] s_axi_csrs_wstrb,
    input  logic                s_axi_csrs_wvalid,
    output logic                s_axi_csrs_wready,
    output logic [1:0]          s_axi_csrs_bresp,
    output logic                s_axi_csrs_bvalid,
    input  logic                s_axi_csrs_bready,
    input  logic [ADDR_W-1:0]   s_axi_csrs_araddr,
    input  logic                s_axi_csrs_arvalid,
    output logic                s_axi_csrs_arready,
    output logic [DATA_W-1:0]   s_axi_csrs_rdata,
    output logic [1:0]          s_axi_csrs_rresp,
    output logic                s_axi_csrs_rvalid,
    input  logic                s_axi_csrs_rready,
    input  logic [DATA_W-1:0]   status_i,
    output logic [DATA_W-1:0]   command_o,
    output logic [DATA_W-1:0]   rxaddr_o,
    output logic [DATA_W-1:0]   txaddr_o,
    output logic [DATA_W-1:0]   t_o,
    output logic [DATA_W-1:0]   t_len_o,
    output logic [DATA_W-1:0]   loading_o,
    output logic                command_wr_o,
    output logic                loading_wr_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int NREG   = 6;

    logic                aw_fire, w_fire, ar_fire;
    logic                aw_hold, w_hold, ar_hold;
    logic                commit;
    logic [ADDR_W-1:0]   awaddr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [DATA_W-1:0]   regs [NREG];
    reg_sel_e            wr_sel, rd_sel;
    logic [2:0]          wr_idx, rd_idx;

    // Word-aligned decode; the two low address bits are ignored.
    function automatic reg_sel_e decode(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] al;
        al = a & ~ADDR_W'(3);
        if (al == ADDR_W'(COMMAND) || al == ADDR_W'(STATUS)) return SEL_COMMAND;
        if (al == ADDR_W'(RXADDR))  return SEL_RXADDR;
        if (al == ADDR_W'(TXADDR))  return SEL_TXADDR;
        if (al == ADDR_W'(T))       return SEL_T;
        if (al == ADDR_W'(T_LEN))   return SEL_T_LEN;
        if (al == ADDR_W'(LOADING)) return SEL_LOADING;
        return SEL_NONE;
    endfunction

    // Byte-lane merge of new write data into the old register value.
    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_val,
                                                      input logic [DATA_W-1:0] new_val,
                                                      input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] r;
        r = old_val;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
        end
        return r;
    endfunction

    assign aw_fire = s_axi_csrs_awvalid && s_axi_csrs_awready;
    assign w_fire  = s_axi_csrs_wvalid  && s_axi_csrs_wready;
    assign ar_fire = s_axi_csrs_arvalid && s_axi_csrs_arready;
    assign commit  = aw_hold && w_hold;
    assign wr_sel  = decode(awaddr_q);
    assign rd_sel  = decode(s_axi_csrs_araddr);
    assign wr_idx  = wr_sel;
    assign rd_idx  = rd_sel;

    axil_ready_pulse u_aw (
        .clk   (clk),
        .rst   (rst),
        .valid (s_axi_csrs_awvalid),
        .block (s_axi_csrs_bvalid),
        .clear (commit),
        .ready (s_axi_csrs_awready),
        .hold  (aw_hold)
    );

    axil_ready_pulse u_w (
        .clk   (clk),
        .rst   (rst),
        .valid (s_axi_csrs_wvalid),
        .block (s_axi_csrs_bvalid),
        .clear (commit),
        .ready (s_axi_csrs_wready),
        .hold  (w_hold)
    );

    // The read is served on the handshake edge itself, so the AR hold only
    // lives for one cycle; rvalid is what blocks further AR beats.
    axil_ready_pulse u_ar (
        .clk   (clk),
        .rst   (rst),
        .valid (s_axi_csrs_arvalid),
        .block (s_axi_csrs_rvalid),
        .clear (ar_hold),
        .ready (s_axi_csrs_arready),
        .hold  (ar_hold)
    );

    // Capture write address and data beats as they are accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            if (aw_fire) awaddr_q <= s_axi_csrs_awaddr;
            if (w_fire) begin
                wdata_q <= s_axi_csrs_wdata;
                wstrb_q <= s_axi_csrs_wstrb;
            end
        end
    end

    // Commit a complete write, raise the B response and the write strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            s_axi_csrs_bvalid <= 1'b0;
            s_axi_csrs_bresp  <= RESP_OKAY;
            command_wr_o      <= 1'b0;
            loading_wr_o      <= 1'b0;
        end else begin
            command_wr_o <= 1'b0;
            loading_wr_o <= 1'b0;
            if (s_axi_csrs_bvalid && s_axi_csrs_bready) begin
                s_axi_csrs_bvalid <= 1'b0;
                s_axi_csrs_bresp  <= RESP_OKAY;
            end
            if (commit) begin
                s_axi_csrs_bvalid <= 1'b1;
                if (wr_sel != SEL_NONE) begin
                    regs[wr_idx]     <= merge_bytes(regs[wr_idx], wdata_q, wstrb_q);
                    s_axi_csrs_bresp <= RESP_OKAY;
                    command_wr_o     <= (wr_sel == SEL_COMMAND);
                    loading_wr_o     <= (wr_sel == SEL_LOADING);
                end else begin
                    s_axi_csrs_bresp <= RESP_SLVERR;
                end
            end
        end
    end

    // Register read data on the AR handshake and hold it until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_axi_csrs_rvalid <= 1'b0;
            s_axi_csrs_rdata  <= '0;
            s_axi_csrs_rresp  <= RESP_OKAY;
        end else if (s_axi_csrs_rvalid && s_axi_csrs_rready) begin
            s_axi_csrs_rvalid <= 1'b0;
            s_axi_csrs_rdata  <= '0;
            s_axi_csrs_rresp  <= RESP_OKAY;
        end else if (ar_fire) begin
            s_axi_csrs_rvalid <= 1'b1;
            case (rd_sel)
                SEL_COMMAND: begin
                    s_axi_csrs_rdata <= status_i;
                    s_axi_csrs_rresp <= RESP_OKAY;
                end
                SEL_NONE: begin
                    s_axi_csrs_rdata <= '0;
                    s_axi_csrs_rresp <= RESP_SLVERR;
                end
                default: begin
                    s_axi_csrs_rdata <= regs[rd_idx];
                    s_axi_csrs_rresp <= RESP_OKAY;
                end
            endcase
        end
    end

    assign command_o = regs[0];
    assign rxaddr_o  = regs[1];
    assign txaddr_o  = regs[2];
    assign t_o       = regs[3];
    assign t_len_o   = regs[4];
    assign loading_o = regs[5];

endmodule

// File: tb/tb_axil_csr_responder.sv
// Directed bench for axil_csr_responder: register writes with aligned and
// skewed AW/W, byte strobes, status reads with backpressure, unmapped
// accesses and reset in the middle of a write response.
module tb_axil_csr_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [11:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] status;
    logic [31:0] command_o, rxaddr_o, txaddr_o, t_o, t_len_o, loading_o;
    logic        command_wr_o, loading_wr_o;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    axil_csr_responder #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .s_axi_csrs_awaddr  (awaddr),
        .s_axi_csrs_awvalid (awvalid),
        .s_axi_csrs_awready (awready),
        .s_axi_csrs_wdata   (wdata),
        .s_axi_csrs_wstrb   (wstrb),
        .s_axi_csrs_wvalid  (wvalid),
        .s_axi_csrs_wready  (wready),
        .s_axi_csrs_bresp   (bresp),
        .s_axi_csrs_bvalid  (bvalid),
        .s_axi_csrs_bready  (bready),
        .s_axi_csrs_araddr  (araddr),
        .s_axi_csrs_arvalid (arvalid),
        .s_axi_csrs_arready (arready),
        .s_axi_csrs_rdata   (rdata),
        .s_axi_csrs_rresp   (rresp),
        .s_axi_csrs_rvalid  (rvalid),
        .s_axi_csrs_rready  (rready),
        .status_i           (status),
        .command_o          (command_o),
        .rxaddr_o           (rxaddr_o),
        .txaddr_o           (txaddr_o),
        .t_o                (t_o),
        .t_len_o            (t_len_o),
        .loading_o          (loading_o),
        .command_wr_o       (command_wr_o),
        .loading_wr_o       (loading_wr_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one write; W is raised wdly cycles after AW. Returns when bvalid
    // rises (bready held low), reporting ready pulse counts and commit timing.
    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int wdly, output logic [1:0] resp, output int awc,
                            output int wc, output logic early, output logic done);
        logic hs_aw, hs_w;
        awc = 0; wc = 0; early = 1'b0; done = 1'b0; resp = 2'b11;
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b0; bready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c == wdly) wvalid = 1'b1;
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            tick();
            if (hs_aw) awvalid = 1'b0;
            if (hs_w)  wvalid  = 1'b0;
            if (awready) awc++;
            if (wready)  wc++;
            if (bvalid) begin
                early = (c < wdly);
                resp  = bresp;
                done  = 1'b1;
                break;
            end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    task automatic b_accept();
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    // Issue one read, then hold rready low for rdly cycles before accepting.
    task automatic do_read(input logic [11:0] a, input int rdly, output logic [31:0] d,
                           output logic [1:0] resp, output int lat, output logic stable);
        logic hs;
        araddr = a; arvalid = 1'b1; rready = 1'b0; lat = -1; stable = 1'b1;
        d = 32'hDEAD_BEEF; resp = 2'b11;
        for (int c = 0; c < 40; c++) begin
            hs = arvalid && arready;
            tick();
            if (hs) arvalid = 1'b0;
            if (rvalid) begin
                lat = c + 1;
                break;
            end
        end
        arvalid = 1'b0;
        d = rdata;
        resp = rresp;
        for (int i = 0; i < rdly; i++) begin
            tick();
            if (rvalid !== 1'b1 || rdata !== d || rresp !== resp) stable = 1'b0;
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        int          awc, wc, lat;
        logic        early, done, stable;

        rst = 1'b1; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0; status = '0;
        tick(); tick();
        rst = 1'b0;

        chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
        chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
        chk("rst_awready", {31'd0, awready}, 32'd0);
        chk("rst_command", command_o, 32'd0);
        chk("rst_loading", loading_o, 32'd0);

        // RXADDR with AW and W together
        do_write(12'h004, 32'h0000_0100, 4'hF, 0, resp, awc, wc, early, done);
        chk("rx_done",    {31'd0, done}, 32'd1);
        chk("rx_awpulse", awc, 32'd1);
        chk("rx_wpulse",  wc, 32'd1);
        chk("rx_bresp",   {30'd0, resp}, 32'd0);
        chk("rx_value",   rxaddr_o, 32'h0000_0100);
        chk("rx_cmdwr",   {31'd0, command_wr_o}, 32'd0);
        b_accept();
        chk("rx_bclear",  {31'd0, bvalid}, 32'd0);

        // LOADING with W three cycles behind AW
        do_write(12'h014, 32'h0000_0009, 4'hF, 3, resp, awc, wc, early, done);
        chk("ld_done",    {31'd0, done}, 32'd1);
        chk("ld_early",   {31'd0, early}, 32'd0);
        chk("ld_awpulse", awc, 32'd1);
        chk("ld_value",   loading_o, 32'd9);
        chk("ld_wr_hi",   {31'd0, loading_wr_o}, 32'd1);
        b_accept();
        chk("ld_wr_lo",   {31'd0, loading_wr_o}, 32'd0);

        // Status read with delayed rready
        status = 32'h0000_0200;
        do_read(12'h000, 5, rd, resp, lat, stable);
        chk("st_latency", lat, 32'd2);
        chk("st_rdata",   rd, 32'h0000_0200);
        chk("st_rresp",   {30'd0, resp}, 32'd0);
        chk("st_stable",  {31'd0, stable}, 32'd1);
        chk("st_rclear",  {31'd0, rvalid}, 32'd0);

        // Partial write with byte strobes
        do_write(12'h00C, 32'h1234_5678, 4'hF, 0, resp, awc, wc, early, done);
        b_accept();
        chk("t_full", t_o, 32'h1234_5678);
        do_write(12'h00C, 32'hAAAA_9985, 4'b0011, 1, resp, awc, wc, early, done);
        chk("t_strb", t_o, 32'h1234_9985);
        b_accept();

        // Unmapped write and read
        do_write(12'h040, 32'hFFFF_FFFF, 4'hF, 0, resp, awc, wc, early, done);
        chk("um_bresp",   {30'd0, resp}, 32'd2);
        chk("um_rx",      rxaddr_o, 32'h0000_0100);
        chk("um_t",       t_o, 32'h1234_9985);
        chk("um_loading", loading_o, 32'd9);
        chk("um_command", command_o, 32'd0);
        b_accept();
        do_read(12'h040, 0, rd, resp, lat, stable);
        chk("um_rdata", rd, 32'd0);
        chk("um_rresp", {30'd0, resp}, 32'd2);

        // Low address bits are ignored on reads
        do_read(12'h006, 0, rd, resp, lat, stable);
        chk("rx_read",  rd, 32'h0000_0100);
        chk("rx_rresp", {30'd0, resp}, 32'd0);

        // Reset while a write response is pending
        do_write(12'h000, 32'h0000_0005, 4'hF, 0, resp, awc, wc, early, done);
        chk("pre_rst_bvalid", {31'd0, bvalid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_bvalid",  {31'd0, bvalid}, 32'd0);
        chk("mid_rst_command", command_o, 32'd0);
        chk("mid_rst_rx",      rxaddr_o, 32'd0);
        chk("mid_rst_t",       t_o, 32'd0);
        chk("mid_rst_loading", loading_o, 32'd0);
        do_write(12'h000, 32'h0000_0001, 4'hF, 0, resp, awc, wc, early, done);
        chk("cmd_done",  {31'd0, done}, 32'd1);
        chk("cmd_value", command_o, 32'd1);
        chk("cmd_wr_hi", {31'd0, command_wr_o}, 32'd1);
        b_accept();
        chk("cmd_wr_lo", {31'd0, command_wr_o}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
